dm_store_buffer: RTL and testbench
==================================

# dm_store_buffer

Posted-write buffer between the CPU MEM-stage datapath and the data memory. Stores are accepted into a small FIFO and drained to the data memory one word per cycle whenever the memory port is not needed by a load. Loads read the data memory directly, with the youngest matching buffered store forwarded over the memory's read data. Word-granular only; byte/half handling stays upstream.

## Interface

- DEPTH, 4, number of buffered stores; power of two, ≥2
- IDX_MSB, 11, upper bit of the word index compared for forwarding and match
- IDX_LSB, 2, lower bit of the word index (byte offset bits ignored)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; reset==0 at a posedge clears all state
- st_valid  in  1  CPU presents a store this cycle
- st_ready  out  1  buffer can accept a store (= !full && reset)
- st_addr  in  32  store byte address
- st_data  in  32  store word
- st_pc  in  32  PC of the store, carried for the memory's write trace
- ld_valid  in  1  CPU performs a load this cycle; owns the memory port
- ld_addr  in  32  load byte address
- ld_data  out  32  load result, forwarded or from memory
- ld_fwd  out  1  ld_data came from a buffered entry
- dm_addr  out  32  data-memory address
- dm_wdata  out  32  data-memory write word
- dm_pc  out  32  PC passed to the memory for tracing
- dm_we  out  1  data-memory write enable
- dm_rdata  in  32  data-memory combinational read data
- empty  out  1  no pending stores; CPU polls before halt/syscall

## Operation

- FIFO state: head/tail pointers, `$clog2(DEPTH)` bits, wrap modulo DEPTH; count, `$clog2(DEPTH+1)` bits; per-entry addr, data, pc.
- Push: at a posedge with st_valid && st_ready, write the entry at tail, tail+1, count+1.
- Drain: dm_we = !empty && !ld_valid && reset. dm_addr/dm_wdata/dm_pc = head entry. At a posedge with dm_we: head+1, count−1.
- Load: when ld_valid, dm_addr = ld_addr, dm_we = 0. When the buffer is empty and !ld_valid, dm_addr/dm_wdata/dm_pc hold the head slot contents (don't-care, dm_we=0).
- Forwarding: compare ld_addr[IDX_MSB:IDX_LSB] against every valid entry. If any match, ld_data = data of the youngest match (closest to tail) and ld_fwd=1. Otherwise ld_data = dm_rdata and ld_fwd=0. Combinational, and evaluated regardless of ld_valid.
- Same-word stores are not coalesced. Each is queued and drained in program order.
- Push and drain in the same cycle: count unchanged, both pointers advance.
- Full: st_ready=0. A store offered while full is not accepted; the CPU stalls. A drain in the same cycle does not make room that cycle.
- Store and load in the same cycle: the load does not see the store being pushed this cycle. The store becomes forwardable next cycle.

## Timing

- Reset (reset==0 at a posedge): head=tail=count=0. Pending stores are discarded, never written, including reset mid-drain.
- While reset==0: st_ready=0, dm_we=0, ld_fwd=0, empty=1.
- Store accepted at edge N: forwardable from cycle N+1. Earliest memory write is at edge N+1 (dm_we high during cycle N+1).
- Each cycle with ld_valid=1 delays draining by one cycle. Loads always complete in the same cycle with zero latency.
- Full DEPTH=4 buffer with no loads: empty rises 4 cycles after the last push.

## Structure

- Package dm_sb_pkg holds:
  - ADDR_W=32 and DATA_W=32
  - default DEPTH and IDX_MSB/IDX_LSB
  - a packed sb_entry_t {addr, data, pc}
- One sub-module, sb_fwd_match: takes the entry array, valid mask, head pointer and load index. It returns hit plus the youngest matching data via a priority search ordered from tail backward.
- The top holds the FIFO registers, pointer/count logic and port muxing.

## Test plan

- Reset and single store: hold reset=0 for 2 cycles, then reset=1. Push st_addr=0x10, st_data=0xDEADBEEF, ld_valid=0.
  - Required: dm_we=1 the next cycle with dm_addr=0x10, dm_wdata=0xDEADBEEF.
  - Required: empty=1 after that edge.
- Fill and stall: push 5 stores back-to-back while holding ld_valid=1.
  - Required: st_ready=0 after the 4th push, and the 5th is not accepted.
  - Release ld_valid. Required: 4 writes in order, then st_ready=1.
- Forward youngest: hold ld_valid=1. Push 0x20←0x1111, then 0x20←0x2222. Load 0x20 (also 0x22, same word).
  - Required: ld_data=0x2222, ld_fwd=1.
  - Required: a load of 0x24 gives ld_fwd=0, ld_data=dm_rdata.
- Load blocks drain: with 2 pending stores, pulse ld_valid for 3 cycles.
  - Required: dm_we=0 and dm_addr=ld_addr during the pulse. Draining resumes afterwards in FIFO order.
- Reset mid-operation: with 3 pending stores, assert reset=0 for one edge.
  - Required: empty=1, dm_we never high for those entries, and ld_fwd=0 for their addresses.
- Pointer wrap: push/drain 10 stores in steady state with simultaneous push and drain.
  - Required: count stays constant, and the write sequence in the memory matches push order exactly.

Source files
------------

// File: rtl/dm_store_buffer_pkg.sv
// Shared types and defaults for the data-memory posted-write store buffer.
package dm_sb_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int SB_DEPTH   = 4;
    localparam int SB_IDX_MSB = 11;
    localparam int SB_IDX_LSB = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } sb_entry_t;

    // Word-index equality; byte-offset bits are ignored by the callers' slicing.
    function automatic logic idx_equal(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/dm_store_buffer_fwd_match.sv
// Store-to-load forwarding search: youngest valid entry whose word index matches the load.
module sb_fwd_match
    import dm_sb_pkg::*;
#(
    parameter int DEPTH   = SB_DEPTH,
    parameter int IDX_MSB = SB_IDX_MSB,
    parameter int IDX_LSB = SB_IDX_LSB,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]      valid,
    input  logic [PTR_W-1:0]      head,
    input  logic [IDX_MSB:IDX_LSB] ld_idx,
    output logic                  hit,
    output logic [DATA_W-1:0]     hit_data
);

    logic [PTR_W-1:0]  slot_s;
    logic [ADDR_W-1:0] entry_idx_s;
    logic [ADDR_W-1:0] load_idx_s;

    // Walk from the youngest position (head+DEPTH-1) back to head; the first valid match wins.
    always_comb begin
        hit         = 1'b0;
        hit_data    = '0;
        slot_s      = '0;
        entry_idx_s = '0;
        load_idx_s  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            slot_s      = head + PTR_W'(k);
            entry_idx_s = '0;
            load_idx_s  = '0;
            entry_idx_s[IDX_MSB-IDX_LSB:0] = entries[slot_s].addr[IDX_MSB:IDX_LSB];
            load_idx_s[IDX_MSB-IDX_LSB:0]  = ld_idx;
            if (!hit && valid[slot_s] && idx_equal(entry_idx_s, load_idx_s)) begin
                hit      = 1'b1;
                hit_data = entries[slot_s].data;
            end else begin
                hit      = hit;
                hit_data = hit_data;
            end
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write store buffer: FIFO of stores drained to data memory when loads leave the port idle.
module dm_store_buffer
    import dm_sb_pkg::*;
#(
    parameter int DEPTH   = SB_DEPTH,
    parameter int IDX_MSB = SB_IDX_MSB,
    parameter int IDX_LSB = SB_IDX_LSB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic [31:0] ld_data,
    output logic        ld_fwd,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc,
    output logic        dm_we,
    input  logic [31:0] dm_rdata,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] entries_r;
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  drain_s;
    logic                  hit_s;
    logic [DATA_W-1:0]     hit_data_s;
    logic [DEPTH-1:0]      valid_s;
    logic [PTR_W-1:0]      offset_s;
    sb_entry_t             head_entry_s;
    sb_entry_t             new_entry_s;

    assign full_s       = (count_r == CNT_W'(DEPTH));
    assign empty_s      = (count_r == CNT_W'(0));
    assign push_s       = st_valid && st_ready;
    assign drain_s      = dm_we;
    assign head_entry_s = entries_r[head_r];
    assign new_entry_s  = '{addr: st_addr, data: st_data, pc: st_pc};

    // Port muxing is combinational: loads complete in the cycle they are issued.
    assign st_ready = !full_s && reset;
    assign dm_we    = !empty_s && !ld_valid && reset;
    assign dm_addr  = ld_valid ? ld_addr : head_entry_s.addr;
    assign dm_wdata = head_entry_s.data;
    assign dm_pc    = head_entry_s.pc;
    assign ld_fwd   = hit_s && reset;
    assign ld_data  = (hit_s && reset) ? hit_data_s : dm_rdata;
    assign empty    = empty_s || !reset;

    // A slot is live when its distance from head is below the occupancy count.
    always_comb begin
        valid_s  = '0;
        offset_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset_s   = PTR_W'(i) - head_r;
            valid_s[i] = (CNT_W'(offset_s) < count_r);
        end
    end

    sb_fwd_match #(
        .DEPTH   (DEPTH),
        .IDX_MSB (IDX_MSB),
        .IDX_LSB (IDX_LSB)
    ) u_fwd_match (
        .entries  (entries_r),
        .valid    (valid_s),
        .head     (head_r),
        .ld_idx   (ld_addr[IDX_MSB:IDX_LSB]),
        .hit      (hit_s),
        .hit_data (hit_data_s)
    );

    // FIFO storage, pointers and occupancy; reset discards everything still pending.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_r    <= '0;
            tail_r    <= '0;
            count_r   <= '0;
            entries_r <= '0;
        end else begin
            if (push_s) begin
                entries_r[tail_r] <= new_entry_s;
                tail_r            <= tail_r + PTR_W'(1);
            end
            if (drain_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, drain_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for dm_store_buffer with a write-log memory model.
module tb_dm_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_fwd;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_pc;
    logic        dm_we;
    logic [31:0] dm_rdata;
    logic        empty;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];

    dm_store_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_pc    (st_pc),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_fwd   (ld_fwd),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_pc    (dm_pc),
        .dm_we    (dm_we),
        .dm_rdata (dm_rdata),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return 32'hA5A5_0000 | {16'h0000, a[15:0]};
    endfunction

    assign dm_rdata = rd_pat(dm_addr);

    always @(posedge clk) begin
        if (dm_we === 1'b1) begin
            wlog_addr.push_back(dm_addr);
            wlog_data.push_back(dm_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input int idx, input logic [31:0] a, input logic [31:0] d);
        check($sformatf("wlog_addr[%0d]", idx), (idx < wlog_addr.size()) ? wlog_addr[idx] : 32'hXXXX_XXXX, a);
        check($sformatf("wlog_data[%0d]", idx), (idx < wlog_data.size()) ? wlog_data[idx] : 32'hXXXX_XXXX, d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    initial begin
        reset    = 1'b0;
        st_valid = 1'b0;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        st_pc    = 32'h0;
        ld_valid = 1'b0;
        ld_addr  = 32'h0;
        step();
        step();
        // Reset state
        check("rst_st_ready", {31'b0, st_ready}, 32'd0);
        check("rst_dm_we",    {31'b0, dm_we},    32'd0);
        check("rst_empty",    {31'b0, empty},    32'd1);
        check("rst_ld_fwd",   {31'b0, ld_fwd},   32'd0);
        reset = 1'b1;
        #1;
        check("post_rst_st_ready", {31'b0, st_ready}, 32'd1);
        check("post_rst_empty",    {31'b0, empty},    32'd1);

        // Single store
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hDEADBEEF; st_pc = 32'h100;
        #1;
        check("single_we_before", {31'b0, dm_we}, 32'd0);
        step();
        st_valid = 1'b0; ld_addr = 32'h10;
        #1;
        check("single_we",    {31'b0, dm_we}, 32'd1);
        check("single_addr",  dm_addr,  32'h10);
        check("single_wdata", dm_wdata, 32'hDEADBEEF);
        check("single_pc",    dm_pc,    32'h100);
        check("single_fwd",   {31'b0, ld_fwd}, 32'd1);
        check("single_fwd_d", ld_data,  32'hDEADBEEF);
        step();
        check("single_empty_after", {31'b0, empty},  32'd1);
        check("single_fwd_after",   {31'b0, ld_fwd}, 32'd0);
        check("single_log_n", wlog_addr.size(), 32'd1);
        check_log(0, 32'h10, 32'hDEADBEEF);
        clear_log();

        // Fill and stall with the port held by loads
        ld_valid = 1'b1; ld_addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            st_valid = 1'b1; st_addr = 32'h40 + 32'(4 * i); st_data = 32'h1000 + 32'(i); st_pc = 32'h400 + 32'(4 * i);
            #1;
            check($sformatf("fill_ready_%0d", i), {31'b0, st_ready}, (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        st_valid = 1'b0;
        #1;
        check("full_ready",   {31'b0, st_ready}, 32'd0);
        check("full_we",      {31'b0, dm_we},    32'd0);
        check("full_dm_addr", dm_addr,  32'h200);
        check("full_ld_data", ld_data,  rd_pat(32'h200));
        check("full_log_n",   wlog_addr.size(), 32'd0);
        ld_addr = 32'h50;
        #1;
        check("fifth_not_fwd", {31'b0, ld_fwd}, 32'd0);
        ld_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("drain_we_%0d", j),    {31'b0, dm_we}, 32'd1);
            check($sformatf("drain_addr_%0d", j),  dm_addr,  32'h40 + 32'(4 * j));
            check($sformatf("drain_wdata_%0d", j), dm_wdata, 32'h1000 + 32'(j));
            step();
        end
        check("drained_empty", {31'b0, empty},    32'd1);
        check("drained_ready", {31'b0, st_ready}, 32'd1);
        check("drained_log_n", wlog_addr.size(),  32'd4);
        clear_log();

        // Forward youngest
        ld_valid = 1'b1; ld_addr = 32'h20;
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h1111; st_pc = 32'h500;
        #1;
        check("fwd_same_cycle", {31'b0, ld_fwd}, 32'd0);
        step();
        st_data = 32'h2222; st_pc = 32'h504;
        #1;
        check("fwd_first",   ld_data, 32'h1111);
        step();
        st_valid = 1'b0;
        #1;
        check("fwd_young_f", {31'b0, ld_fwd}, 32'd1);
        check("fwd_young_d", ld_data, 32'h2222);
        ld_addr = 32'h22;
        #1;
        check("fwd_off_d",   ld_data, 32'h2222);
        ld_addr = 32'h1020;
        #1;
        check("fwd_alias_f", {31'b0, ld_fwd}, 32'd1);
        ld_addr = 32'h24;
        #1;
        check("fwd_miss_f",  {31'b0, ld_fwd}, 32'd0);
        check("fwd_miss_d",  ld_data, rd_pat(32'h24));
        ld_valid = 1'b0;
        step();
        step();
        check("fwd_log_n", wlog_addr.size(), 32'd2);
        check_log(0, 32'h20, 32'h1111);
        check_log(1, 32'h20, 32'h2222);
        clear_log();

        // Loads block drain
        ld_valid = 1'b1; ld_addr = 32'h300;
        st_valid = 1'b1; st_addr = 32'h80; st_data = 32'hAAAA; st_pc = 32'h600;
        step();
        st_addr = 32'h84; st_data = 32'hBBBB; st_pc = 32'h604;
        step();
        st_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("blk_we_%0d", k),   {31'b0, dm_we}, 32'd0);
            check($sformatf("blk_addr_%0d", k), dm_addr, 32'h300);
            step();
        end
        ld_valid = 1'b0;
        #1;
        check("blk_resume_addr0", dm_addr, 32'h80);
        step();
        check("blk_resume_addr1", dm_addr, 32'h84);
        step();
        check("blk_empty", {31'b0, empty}, 32'd1);
        check("blk_log_n", wlog_addr.size(), 32'd2);
        check_log(0, 32'h80, 32'hAAAA);
        check_log(1, 32'h84, 32'hBBBB);
        clear_log();

        // Reset mid-operation
        ld_valid = 1'b1; ld_addr = 32'h700;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 32'hC0 + 32'(4 * i); st_data = 32'h7000 + 32'(i); st_pc = 32'h800;
            step();
        end
        st_valid = 1'b0; ld_valid = 1'b0; reset = 1'b0;
        #1;
        check("mid_rst_we",    {31'b0, dm_we},    32'd0);
        check("mid_rst_empty", {31'b0, empty},    32'd1);
        check("mid_rst_ready", {31'b0, st_ready}, 32'd0);
        step();
        reset = 1'b1; ld_addr = 32'hC4;
        #1;
        check("mid_post_empty", {31'b0, empty},  32'd1);
        check("mid_post_we",    {31'b0, dm_we},  32'd0);
        check("mid_post_fwd",   {31'b0, ld_fwd}, 32'd0);
        step();
        step();
        check("mid_log_n", wlog_addr.size(), 32'd0);

        // Pointer wrap with steady push+drain
        for (int i = 0; i < 10; i++) begin
            st_valid = 1'b1; st_addr = 32'h100 + 32'(4 * i); st_data = 32'h5000 + 32'(i); st_pc = 32'h900 + 32'(4 * i);
            if (i > 0) begin
                #1;
                check($sformatf("wrap_we_%0d", i),   {31'b0, dm_we}, 32'd1);
                check($sformatf("wrap_addr_%0d", i), dm_addr, 32'h100 + 32'(4 * (i - 1)));
                check($sformatf("wrap_rdy_%0d", i),  {31'b0, st_ready}, 32'd1);
            end
            step();
        end
        st_valid = 1'b0;
        #1;
        check("wrap_last_addr", dm_addr, 32'h124);
        step();
        check("wrap_empty", {31'b0, empty}, 32'd1);
        check("wrap_log_n", wlog_addr.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check_log(i, 32'h100 + 32'(4 * i), 32'h5000 + 32'(i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
